freq_gen: RTL and testbench
===========================

FREQ_GEN -- requirements
Module: freq_gen

Interface
REQ-001 SHALL have parameter CLK_FS, default 375_000_000, giving the reference clock frequency in Hz.
REQ-002 SHALL have parameter FREQ_W, default 20, giving the requested-frequency width.
REQ-003 SHALL have parameter CNT_W, default 32, giving the divider and period-counter width.
REQ-004 clk_fs  input  1  sole clock; all logic on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 freq_set  input  FREQ_W  requested output frequency in Hz.
REQ-007 load  input  1  one-cycle strobe; accepted only while busy=0.
REQ-008 clk_out  output  1  generated square wave, about 50% duty.
REQ-009 busy  output  1  high from load acceptance until the new setting takes effect.
REQ-010 done  output  1  one-cycle pulse when the new setting takes effect.
REQ-011 err  output  1  high when the active setting is freq_set=0.
REQ-012 half_period  output  CNT_W  active half-period, in clk_fs cycles.

Function
REQ-013 FSM states SHALL be IDLE, DIV, WAIT_EDGE, APPLY; reset state SHALL be IDLE.
REQ-014 IDLE with load=1: latch freq_set, set busy=1, go to DIV next cycle; otherwise stay in IDLE.
REQ-015 DIV: compute q = CLK_FS / (2*freq_latched), truncating, by restoring division at one quotient bit per cycle; exactly CNT_W cycles in DIV.
REQ-016 Division arithmetic SHALL be unsigned CNT_W-bit with a CNT_W+1-bit partial remainder; divisor 2*freq_latched SHALL be formed at FREQ_W+1 bits without overflow.
REQ-017 q=0 (freq_latched > CLK_FS/2) SHALL be clamped to 1.
REQ-018 freq_latched=0 SHALL skip DIV, go straight to APPLY, and set err=1 with clk_out forced low.
REQ-019 After DIV, if the generator is running, go to WAIT_EDGE; if the generator is stopped (after reset or err=1), go to APPLY.
REQ-020 WAIT_EDGE: stay until the half counter expires with clk_out=0, which marks the end of a full period; then go to APPLY.
REQ-021 APPLY (1 cycle): write half_period, clear the half counter, clear err for a nonzero setting, pulse done=1, clear busy, return to IDLE.
REQ-022 Generator: half counter increments each cycle; on reaching half_period-1 it SHALL wrap to 0 and toggle clk_out.
REQ-023 Output period SHALL be 2*half_period cycles.
REQ-024 The first toggle after APPLY SHALL occur half_period cycles later.
REQ-025 Retuning SHALL be glitch-free: no high or low phase shorter than min(old, new) half_period.
REQ-026 load while busy=1 SHALL be ignored: no state change and the latched value is unchanged.
REQ-027 load in the APPLY cycle SHALL be ignored.
REQ-028 load in the first IDLE cycle after APPLY SHALL be accepted.
REQ-029 Load-to-done latency SHALL be CNT_W+2 cycles when stopped.
REQ-030 When running, load-to-done latency SHALL be CNT_W+2 cycles plus up to one output period.

Reset
REQ-031 Reset SHALL drive clk_out=0, busy=0, done=0, err=0, half_period=0 and state=IDLE, and clear the half counter, divider registers and latched frequency.
REQ-032 With half_period=0 the generator SHALL be stopped: clk_out held low, counter held at 0.
REQ-033 Reset asserted mid-DIV or mid-WAIT_EDGE SHALL abort the operation without a done pulse.
REQ-034 After reset release the first edge SHALL be IDLE.

Structure
REQ-035 Shared package freq_gen_pkg SHALL hold the CLK_FS default, the FREQ_W/CNT_W defaults and the FSM state encoding.
REQ-036 The restoring divider SHALL be one sub-module, seq_div, with ports start, dividend, divisor, quotient and valid.
REQ-037 The FSM and generator SHALL stay in freq_gen.

Verification
REQ-038 Reset, then load freq_set=1_000_000 -> done after 34 cycles, half_period=187, clk_out period 374 cycles.
REQ-039 Running at 1_000_000, load 500_000 -> half_period=375 applied only at a period boundary; no phase shorter than 187 cycles.
REQ-040 Load freq_set=50 -> half_period=3_750_000, period 7_500_000 cycles.
REQ-041 Load freq_set=0 -> done after 2 cycles, err=1, clk_out low.
REQ-042 After REQ-041, load 1_000_000 -> err=0 and toggling resumes.
REQ-043 Load 1_000_000, second load 2_000 at cycle 5 -> ignored; half_period=187.
REQ-044 Load 1_000_000, then rst_n low at cycle 10 of DIV -> no done, all outputs 0; after release, load 2_000 -> half_period=93_750.

Source files
------------

// File: rtl/freq_gen_pkg.sv
// freq_gen_pkg
// Shared defaults and FSM state encoding for the frequency generator.
//   CLK_FS_DEF : reference clock frequency in Hz
//   FREQ_W_DEF : requested-frequency width
//   CNT_W_DEF  : divider / period-counter width
//   state_t    : sequencing FSM states
package freq_gen_pkg;

  localparam int unsigned CLK_FS_DEF = 375_000_000;
  localparam int unsigned FREQ_W_DEF = 20;
  localparam int unsigned CNT_W_DEF  = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DIV       = 2'd1,
    WAIT_EDGE = 2'd2,
    APPLY     = 2'd3
  } state_t;

endpackage

// File: rtl/freq_gen_div.sv
// seq_div
// Sequential restoring divider, one quotient bit per clock.
// The first quotient bit is produced on the start edge itself, so a result
// is ready N_W cycles after start, flagged by valid (held until next start).
// A divisor of zero is never issued by the parent.
//   clk_fs   : clock
//   rst_n    : async active-low reset
//   start    : one-cycle strobe, samples dividend/divisor
//   dividend : N_W-bit unsigned dividend
//   divisor  : D_W-bit unsigned divisor (D_W <= N_W+1)
//   quotient : truncated quotient
//   valid    : result ready
module seq_div #(
  parameter int unsigned N_W = 32,
  parameter int unsigned D_W = 21
) (
  input  logic           clk_fs,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic [N_W-1:0] quotient,
  output logic           valid
);

  localparam int unsigned LW = $clog2(N_W + 1);

  logic [N_W:0]   r_rem;
  logic [N_W-1:0] r_quo;
  logic [D_W-1:0] r_dv;
  logic [LW-1:0]  r_left;
  logic           r_valid;

  logic [N_W:0]   w_rem_in;
  logic [N_W:0]   w_rem_sh;
  logic [N_W:0]   w_rem_nxt;
  logic [N_W:0]   w_dv;
  logic [N_W-1:0] w_quo_in;
  logic [N_W-1:0] w_quo_nxt;
  logic           w_fit;

  // The quotient register doubles as the dividend shifter: dividend bits
  // leave at the MSB while quotient bits enter at the LSB.
  always_comb begin
    w_rem_in  = start ? '0 : r_rem;
    w_quo_in  = start ? dividend : r_quo;
    w_dv      = (N_W+1)'(start ? divisor : r_dv);
    w_rem_sh  = {w_rem_in[N_W-1:0], w_quo_in[N_W-1]};
    // A set top bit means the shifted value overflowed and certainly fits.
    w_fit     = w_rem_in[N_W] || (w_rem_sh >= w_dv);
    w_rem_nxt = w_fit ? (w_rem_sh - w_dv) : w_rem_sh;
    w_quo_nxt = {w_quo_in[N_W-2:0], w_fit};
  end

  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      r_rem   <= '0;
      r_quo   <= '0;
      r_dv    <= '0;
      r_left  <= '0;
      r_valid <= 1'b0;
    end else if (start) begin
      r_rem   <= w_rem_nxt;
      r_quo   <= w_quo_nxt;
      r_dv    <= divisor;
      r_left  <= LW'(N_W - 1);
      r_valid <= (N_W == 1);
    end else if (r_left != '0) begin
      r_rem   <= w_rem_nxt;
      r_quo   <= w_quo_nxt;
      r_left  <= r_left - 1'b1;
      r_valid <= (r_left == LW'(1));
    end
  end

  assign quotient = r_quo;
  assign valid    = r_valid;

endmodule

// File: rtl/freq_gen.sv
// freq_gen
// Programmable square-wave generator. A load computes the half period
// CLK_FS/(2*freq) with a sequential divider and swaps it in at a period
// boundary so the output never shows a short phase.
//   clk_fs      : reference clock
//   rst_n       : async active-low reset
//   freq_set    : requested output frequency in Hz
//   load        : one-cycle strobe, accepted only while busy=0
//   clk_out     : generated square wave
//   busy        : setting in progress
//   done        : one-cycle pulse when the new setting takes effect
//   err         : active setting is 0 Hz (output held low)
//   half_period : active half period in clk_fs cycles
//
// state     | meaning
// ----------+-------------------------------------------------------
// IDLE      | waiting for load
// DIV       | divider running, CNT_W cycles
// WAIT_EDGE | generator running; wait for the end of its low phase
// APPLY     | write new half period, restart counter, pulse done
module freq_gen
  import freq_gen_pkg::*;
#(
  parameter int unsigned CLK_FS = CLK_FS_DEF,
  parameter int unsigned FREQ_W = FREQ_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk_fs,
  input  logic              rst_n,
  input  logic [FREQ_W-1:0] freq_set,
  input  logic              load,
  output logic              clk_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  half_period
);

  localparam logic [CNT_W-1:0] DIVIDEND = CNT_W'(CLK_FS);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [FREQ_W-1:0] r_freq;
  logic [CNT_W-1:0]  r_half_cnt;
  logic [CNT_W-1:0]  r_half_period;
  logic              r_clk_out;
  logic              r_err;
  logic              r_done;

  logic              w_accept;
  logic              w_apply;
  logic              w_div_start;
  logic              w_div_valid;
  logic              w_running;
  logic              w_expire;
  logic [FREQ_W:0]   w_divisor;
  logic [CNT_W-1:0]  w_quot;
  logic [CNT_W-1:0]  w_new_half;

  assign w_running  = (r_half_period != '0);
  assign w_expire   = w_running && (r_half_cnt == r_half_period - 1'b1);
  assign w_divisor  = {freq_set, 1'b0};
  // Requests above CLK_FS/2 truncate to zero; run as fast as possible.
  assign w_new_half = (w_quot == '0) ? CNT_W'(1) : w_quot;
  // A 0 Hz request never reaches the divider.
  assign w_div_start = w_accept && (freq_set != '0);

  seq_div #(
    .N_W (CNT_W),
    .D_W (FREQ_W + 1)
  ) u_div (
    .clk_fs   (clk_fs),
    .rst_n    (rst_n),
    .start    (w_div_start),
    .dividend (DIVIDEND),
    .divisor  (w_divisor),
    .quotient (w_quot),
    .valid    (w_div_valid)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_apply     = 1'b0;
    case (r_state)
      IDLE: begin
        if (load) begin
          w_accept    = 1'b1;
          w_state_nxt = (freq_set == '0) ? APPLY : DIV;
        end
      end
      DIV: begin
        if (w_div_valid) begin
          w_state_nxt = w_running ? WAIT_EDGE : APPLY;
        end
      end
      WAIT_EDGE: begin
        // Low phase ending closes a full period; the toggle to high happens
        // on this same edge and APPLY restarts the count from there.
        if (w_expire && !r_clk_out) begin
          w_state_nxt = APPLY;
        end
      end
      APPLY: begin
        w_apply     = 1'b1;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      r_freq        <= '0;
      r_half_cnt    <= '0;
      r_half_period <= '0;
      r_clk_out     <= 1'b0;
      r_err         <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done <= w_apply;
      if (w_accept) begin
        r_freq <= freq_set;
      end
      if (w_apply) begin
        r_half_cnt <= '0;
        if (r_freq == '0) begin
          r_err         <= 1'b1;
          r_half_period <= '0;
          r_clk_out     <= 1'b0;
        end else begin
          r_err         <= 1'b0;
          r_half_period <= w_new_half;
        end
      end else if (!w_running) begin
        r_half_cnt <= '0;
        r_clk_out  <= 1'b0;
      end else if (w_expire) begin
        r_half_cnt <= '0;
        r_clk_out  <= ~r_clk_out;
      end else begin
        r_half_cnt <= r_half_cnt + 1'b1;
      end
    end
  end

  assign clk_out     = r_clk_out;
  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign err         = r_err;
  assign half_period = r_half_period;

endmodule

// File: tb/tb_freq_gen.sv
// tb_freq_gen
// Directed bench for freq_gen. Each load pushes its expected result
// (half period, err, load-to-done latency window) into a queue; a monitor
// pops and compares on every done pulse. Output phases are tracked
// separately for period and glitch checks.
module tb_freq_gen;

  localparam int unsigned FREQ_W = 20;
  localparam int unsigned CNT_W  = 32;

  logic              clk_fs = 1'b0;
  logic              rst_n;
  logic [FREQ_W-1:0] freq_set;
  logic              load;
  logic              clk_out;
  logic              busy;
  logic              done;
  logic              err;
  logic [CNT_W-1:0]  half_period;

  freq_gen #(
    .CLK_FS (375_000_000),
    .FREQ_W (FREQ_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_fs      (clk_fs),
    .rst_n       (rst_n),
    .freq_set    (freq_set),
    .load        (load),
    .clk_out     (clk_out),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .half_period (half_period)
  );

  always #5 clk_fs = ~clk_fs;

  typedef struct {
    longint hp;
    bit     er;
    longint load_cyc;
    longint lat_min;
    longint lat_max;
    string  tag;
  } exp_t;

  exp_t   sb_q[$];
  int     n_total = 0;
  int     n_pass  = 0;
  longint cyc = 0;
  longint done_total = 0;
  longint last_done_cyc = 0;
  longint rise_cnt = 0;
  longint last_rise_cyc = 0;
  longint run_len = 0;
  longint min_phase = 0;
  bit     trk_en = 1'b0;
  bit     seen_edge = 1'b0;
  logic   prev_co = 1'b0;

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  always @(posedge clk_fs) cyc++;

  // Scoreboard monitor
  always @(negedge clk_fs) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      done_total++;
      last_done_cyc = cyc;
      if (sb_q.size() == 0) begin
        chk(1'b0, "unexpected_done", 1, 0);
      end else begin
        exp_t   e;
        longint lat;
        e   = sb_q.pop_front();
        lat = cyc - e.load_cyc;
        chk(longint'(half_period) == e.hp, {e.tag, "_half_period"}, longint'(half_period), e.hp);
        chk(err === e.er, {e.tag, "_err"}, longint'(err), longint'(e.er));
        chk(lat >= e.lat_min && lat <= e.lat_max, {e.tag, "_latency"}, lat, e.lat_min);
      end
    end
  end

  // Output phase tracker
  always @(negedge clk_fs) begin
    if (clk_out !== prev_co) begin
      if (trk_en && seen_edge && run_len < min_phase) min_phase = run_len;
      if (trk_en) seen_edge = 1'b1;
      if (clk_out === 1'b1) begin
        rise_cnt++;
        last_rise_cyc = cyc;
      end
      run_len = 1;
    end else begin
      run_len++;
    end
    prev_co = clk_out;
  end

  task automatic do_load(input logic [FREQ_W-1:0] f, input bit expect_done, input longint hp,
                         input bit er, input longint lmin, input longint lmax, input string tag);
    exp_t e;
    @(negedge clk_fs);
    freq_set = f;
    load     = 1'b1;
    if (expect_done) begin
      e.hp = hp; e.er = er; e.load_cyc = cyc; e.lat_min = lmin; e.lat_max = lmax; e.tag = tag;
      sb_q.push_back(e);
    end
    @(negedge clk_fs);
    load = 1'b0;
    chk(busy === 1'b1, {tag, "_busy"}, longint'(busy), 1);
  endtask

  task automatic wait_sb(input int max_cyc, input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < max_cyc) begin
      @(posedge clk_fs);
      n++;
    end
    if (sb_q.size() != 0) begin
      chk(1'b0, {name, "_done_timeout"}, longint'(n), longint'(max_cyc));
      sb_q.delete();
    end
  endtask

  task automatic wait_rise(input int max_cyc, input string name, output longint rc);
    longint start = rise_cnt;
    int     n = 0;
    while (rise_cnt == start && n < max_cyc) begin
      @(posedge clk_fs);
      n++;
    end
    if (rise_cnt == start) chk(1'b0, {name, "_rise_timeout"}, longint'(n), longint'(max_cyc));
    rc = last_rise_cyc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint d, r1, r2, dn0;
    int     bad;

    rst_n    = 1'b0;
    load     = 1'b0;
    freq_set = '0;
    repeat (3) @(negedge clk_fs);
    chk(clk_out === 1'b0, "rst_clk_out", longint'(clk_out), 0);
    chk(busy === 1'b0, "rst_busy", longint'(busy), 0);
    chk(done === 1'b0, "rst_done", longint'(done), 0);
    chk(err === 1'b0, "rst_err", longint'(err), 0);
    chk(half_period === '0, "rst_half_period", longint'(half_period), 0);
    rst_n = 1'b1;

    // 1 MHz from stopped
    do_load(1_000_000, 1'b1, 187, 1'b0, 34, 34, "t1");
    wait_sb(60, "t1");
    d = last_done_cyc;
    wait_rise(400, "t1", r1);
    chk(r1 - d == 187, "t1_first_toggle", r1 - d, 187);
    wait_rise(800, "t1", r2);
    chk(r2 - r1 == 374, "t1_period", r2 - r1, 374);

    // retune to 500 kHz while running
    min_phase = 64'd1 << 40;
    seen_edge = 1'b0;
    trk_en    = 1'b1;
    do_load(500_000, 1'b1, 375, 1'b0, 35, 34 + 374, "t2");
    wait_sb(500, "t2");
    chk(last_rise_cyc == last_done_cyc - 1, "t2_boundary", last_done_cyc - last_rise_cyc, 1);
    d = last_done_cyc;
    wait_rise(1000, "t2", r1);
    chk(r1 - d == 750, "t2_first_period", r1 - d, 750);
    wait_rise(1000, "t2", r2);
    chk(r2 - r1 == 750, "t2_period", r2 - r1, 750);
    trk_en = 1'b0;
    chk(min_phase >= 187, "t2_min_phase", min_phase, 187);

    // 50 Hz
    do_load(50, 1'b1, 3_750_000, 1'b0, 35, 34 + 750, "t3");
    wait_sb(900, "t3");

    // 0 Hz: error, output low
    do_load(0, 1'b1, 0, 1'b1, 2, 2, "t4");
    wait_sb(10, "t4");
    bad = 0;
    repeat (50) begin
      @(negedge clk_fs);
      if (clk_out !== 1'b0) bad++;
    end
    chk(bad == 0, "t4_clk_low", longint'(bad), 0);

    // recover from error
    do_load(1_000_000, 1'b1, 187, 1'b0, 34, 34, "t5");
    wait_sb(60, "t5");
    d = last_done_cyc;
    wait_rise(400, "t5", r1);
    chk(r1 - d == 187, "t5_first_toggle", r1 - d, 187);

    // second load while busy is ignored
    do_load(1_000_000, 1'b1, 187, 1'b0, 35, 34 + 374, "t6");
    repeat (4) @(negedge clk_fs);
    freq_set = 2_000;
    load     = 1'b1;
    chk(busy === 1'b1, "t6_busy_at_ignored_load", longint'(busy), 1);
    @(negedge clk_fs);
    load = 1'b0;
    wait_sb(500, "t6");

    // load held through APPLY (ignored) and into first IDLE cycle (accepted)
    begin
      exp_t e;
      @(negedge clk_fs);
      freq_set = 0;
      load     = 1'b1;
      e.hp = 0; e.er = 1'b1; e.load_cyc = cyc; e.lat_min = 2; e.lat_max = 2; e.tag = "t7a";
      sb_q.push_back(e);
      @(negedge clk_fs);
      freq_set = 2_000;
      @(negedge clk_fs);
      freq_set = 1_000;
      e.hp = 187_500; e.er = 1'b0; e.load_cyc = cyc; e.lat_min = 34; e.lat_max = 34; e.tag = "t7b";
      sb_q.push_back(e);
      @(negedge clk_fs);
      load = 1'b0;
      chk(busy === 1'b1, "t7_busy", longint'(busy), 1);
    end
    wait_sb(60, "t7");

    // reset in the middle of DIV aborts without done
    dn0 = done_total;
    do_load(1_000_000, 1'b0, 0, 1'b0, 0, 0, "t8");
    repeat (9) @(negedge clk_fs);
    rst_n = 1'b0;
    #1;
    chk({clk_out, busy, done, err} === 4'b0000, "t8_rst_flags", longint'({clk_out, busy, done, err}), 0);
    chk(half_period === '0, "t8_rst_half_period", longint'(half_period), 0);
    repeat (3) @(negedge clk_fs);
    rst_n = 1'b1;
    repeat (50) @(negedge clk_fs);
    chk(done_total == dn0, "t8_no_done", done_total - dn0, 0);
    chk(clk_out === 1'b0, "t8_stopped", longint'(clk_out), 0);

    do_load(2_000, 1'b1, 93_750, 1'b0, 34, 34, "t9");
    wait_sb(60, "t9");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
